// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: forwarding-mux selects, control-zeroing select and
// pipeline register load/flush enables for the 5-stage RV32I core.
// A small registered FSM (RUN/BUBBLE/FLUSH) sequences load-use bubbles,
// mispredict flushes and cache-miss freezes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_fwd_ctrl #(
  parameter int REG_IDX_W    = 5,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rs1,
  input  logic [REG_IDX_W-1:0] ex_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 mem_regwrite,
  input  logic                 wb_regwrite,
  input  logic [3:0]           mem_wbsel,
  input  logic [3:0]           wb_wbsel,
  input  logic                 br_mispredict,
  input  logic                 icache_stall,
  input  logic                 dcache_stall,
  output logic [2:0]           fwd_a_sel,
  output logic [2:0]           fwd_b_sel,
  output logic                 ctrl_sel,
  output logic                 pc_load,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  // regfilemux select values that need a non-ALU forwarding path
  localparam logic [3:0] WB_BR_EN = 4'd1;
  localparam logic [3:0] WB_U_IMM = 4'd2;

  logic [1:0] state, state_nxt;
  logic [1:0] flush_cnt, flush_cnt_nxt;
  logic       lu, frz, accept_mp;

  // Select encoding for one EX operand; EX/MEM beats MEM/WB, x0 never forwards
  function automatic logic [2:0] fwd_sel(
    input logic [REG_IDX_W-1:0] src,
    input logic                 m_we,
    input logic [REG_IDX_W-1:0] m_rd,
    input logic [3:0]           m_sel,
    input logic                 w_we,
    input logic [REG_IDX_W-1:0] w_rd,
    input logic [3:0]           w_sel
  );
    logic [2:0] r;
    r = 3'b000;
    if (src == '0) begin
      r = 3'b000;
    end else if (m_we && m_rd == src) begin
      if (m_sel == WB_U_IMM)      r = 3'b110;
      else if (m_sel == WB_BR_EN) r = 3'b011;
      else                        r = 3'b010;
    end else if (w_we && w_rd == src) begin
      if (w_sel == WB_U_IMM)      r = 3'b101;
      else if (w_sel == WB_BR_EN) r = 3'b111;
      else                        r = 3'b001;
    end
    return r;
  endfunction

  assign lu  = ex_is_load && (ex_rd != '0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign frz = icache_stall || dcache_stall;

  // Output decode and next-state; reset forces the idle defaults immediately
  always_comb begin
    fwd_a_sel     = fwd_sel(ex_rs1, mem_regwrite, mem_rd, mem_wbsel, wb_regwrite, wb_rd, wb_wbsel);
    fwd_b_sel     = fwd_sel(ex_rs2, mem_regwrite, mem_rd, mem_wbsel, wb_regwrite, wb_rd, wb_wbsel);
    ctrl_sel      = 1'b1;
    pc_load       = 1'b1;
    if_id_load    = 1'b1;
    id_ex_load    = 1'b1;
    ex_mem_load   = 1'b1;
    mem_wb_load   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    accept_mp     = 1'b0;
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (!rst) begin
      fwd_a_sel     = 3'b000;
      fwd_b_sel     = 3'b000;
      state_nxt     = ST_RUN;
      flush_cnt_nxt = 2'd0;
    end else begin
      case (state)
        ST_RUN, ST_BUBBLE: begin
          if (frz) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
          end else if (br_mispredict) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            accept_mp   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt     = ST_FLUSH;
              flush_cnt_nxt = FLUSH_INIT;
            end else begin
              state_nxt = ST_RUN;
            end
          end else if (lu && state == ST_RUN) begin
            pc_load    = 1'b0;
            if_id_load = 1'b0;
            ctrl_sel   = 1'b0;
            state_nxt  = ST_BUBBLE;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (frz) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
          end else begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            flush_cnt_nxt = flush_cnt - 2'd1;
            if (flush_cnt <= 2'd1) begin
              state_nxt     = ST_RUN;
              flush_cnt_nxt = 2'd0;
            end
          end
        end
        default: begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = 2'd0;
        end
      endcase
    end
  end

  // FSM state and flush counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating stall-cycle and accepted-mispredict counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (!pc_load && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (accept_mp && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule
